// File: rtl/aes_dec_stream_ctrl.sv
// rtl/aes_dec_stream_ctrl.sv - AES decryption core sequencer: key load, block feed, watchdog, buffered output
// Optional CBC chaining is enabled by defining AES_CBC_EN.
module aes_dec_stream_ctrl #(
    parameter int KEY_WAIT_CYCLES = 10,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CNT_W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_key_valid,
    input  logic [127:0] cfg_key,
    input  logic         cfg_mode,
    input  logic [127:0] cfg_iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         core_kld,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic         core_mode,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic         key_loaded,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEYLD = 3'd1,
        S_KWAIT = 3'd2,
        S_READY = 3'd3,
        S_LOAD  = 3'd4,
        S_WAIT  = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] KWAIT_LAST = CNT_W'(KEY_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     key_q;
    logic             mode_q;
    logic [127:0]     text_q;
    logic             last_q;
    logic [127:0]     out_data_q;
    logic             err_q;

    logic key_take;
    logic blk_accept;
    logic capture;
    logic timeout;
    logic [127:0] result;

    // A key pulse is only honoured when no block is in flight.
    assign key_take   = cfg_key_valid && (state == S_IDLE || state == S_READY);
    assign blk_accept = (state == S_READY) && in_valid && !cfg_key_valid;
    assign capture    = (state == S_WAIT) && core_done;
    assign timeout    = (state == S_WAIT) && !core_done && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cfg_key_valid) state_nxt = S_KEYLD;
            S_KEYLD: state_nxt = S_KWAIT;
            S_KWAIT: if (cnt == KWAIT_LAST) state_nxt = S_READY;
            S_READY: begin
                if (cfg_key_valid)  state_nxt = S_KEYLD;
                else if (in_valid)  state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (core_done)          state_nxt = S_OUT;
                else if (cnt == TO_LAST) state_nxt = S_READY;
            end
            S_OUT:   if (out_ready) state_nxt = S_READY;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_KWAIT || state == S_WAIT)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

`ifdef AES_CBC_EN
    logic [127:0] iv_q;
    logic [127:0] chain_q;

    assign result = core_text_out ^ chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q    <= '0;
            chain_q <= '0;
        end else if (key_take) begin
            iv_q    <= cfg_iv;
            chain_q <= cfg_iv;
        end else if (capture) begin
            chain_q <= text_q;
        end else if (timeout) begin
            chain_q <= iv_q;
        end else if (state == S_OUT && out_ready && last_q) begin
            chain_q <= iv_q;
        end
    end
`else
    logic unused_iv;

    assign unused_iv = ^cfg_iv;
    assign result    = core_text_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q      <= '0;
            mode_q     <= 1'b0;
            text_q     <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (key_take) begin
                key_q  <= cfg_key;
                mode_q <= cfg_mode;
                err_q  <= 1'b0;
            end
            if (blk_accept) begin
                text_q <= in_data;
                last_q <= in_last;
            end
            if (capture)
                out_data_q <= result;
            if (timeout)
                err_q <= 1'b1;
        end
    end

    assign in_ready     = (state == S_READY) && !cfg_key_valid;
    assign out_valid    = (state == S_OUT);
    assign out_data     = out_data_q;
    assign out_last     = last_q;
    assign core_kld     = (state == S_KEYLD);
    assign core_ld      = (state == S_LOAD);
    assign core_key     = key_q;
    assign core_mode    = mode_q;
    assign core_text_in = text_q;
    assign key_loaded   = (state == S_READY) || (state == S_LOAD) ||
                          (state == S_WAIT)  || (state == S_OUT);
    assign busy         = (state != S_IDLE) && (state != S_READY);
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// tb/tb_aes_dec_stream_ctrl.sv - directed self-checking bench for aes_dec_stream_ctrl
module tb_aes_dec_stream_ctrl;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV  = {128{1'b1}};
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_CBC_EN
    localparam logic [127:0] EXP_IV    = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] EXP_CHAIN = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
`else
    localparam logic [127:0] EXP_IV    = PT;
    localparam logic [127:0] EXP_CHAIN = PT;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_key_valid;
    logic [127:0] cfg_key;
    logic         cfg_mode;
    logic [127:0] cfg_iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         core_kld;
    logic         core_ld;
    logic [127:0] core_key;
    logic         core_mode;
    logic [127:0] core_text_in;
    logic         core_done;
    logic [127:0] core_text_out;
    logic         key_loaded;
    logic         busy;
    logic         err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic done_en;
    int   core_lat;
    int   dly;

    aes_dec_stream_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_key_valid(cfg_key_valid), .cfg_key(cfg_key), .cfg_mode(cfg_mode), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_kld(core_kld), .core_ld(core_ld), .core_key(core_key), .core_mode(core_mode),
        .core_text_in(core_text_in), .core_done(core_done), .core_text_out(core_text_out),
        .key_loaded(key_loaded), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Core stand-in: answers PT core_lat cycles after the load strobe.
    assign core_text_out = PT;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly       <= 0;
            core_done <= 1'b0;
        end else begin
            core_done <= done_en && (dly == 1);
            if (core_ld)      dly <= core_lat;
            else if (dly > 0) dly <= dly - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input string tag);
        int n;
        cfg_key = KEY;
        cfg_iv = IV;
        cfg_mode = 1'b1;
        cfg_key_valid = 1'b1;
        tick();
        cfg_key_valid = 1'b0;
        chk({tag, " kld"}, core_kld, 1);
        n = 0;
        while (!key_loaded && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " kwait_cycles"}, n, 11);
    endtask

    task automatic send_block(input string tag, input logic [127:0] data, input logic last,
                              input logic [127:0] exp);
        int n;
        in_data = data;
        in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, " core_ld"}, core_ld, 1);
        chk({tag, " core_text_in"}, core_text_in, data);
        tick();
        chk({tag, " core_ld_one"}, core_ld, 0);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " out_data"}, out_data, exp);
        chk({tag, " out_last"}, out_last, last);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int n;
        int bad_vld;
        int bad_data;
        int bad_rdy;
        rst = 1'b1;
        cfg_key_valid = 1'b0;
        cfg_key = '0;
        cfg_mode = 1'b0;
        cfg_iv = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        done_en = 1'b1;
        core_lat = 2;
        tick();
        tick();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst key_loaded", key_loaded, 0);
        chk("rst busy", busy, 0);
        chk("rst core_key", core_key, 0);
        rst = 1'b0;
        tick();

        // Key load, then the three-block chaining sequence.
        load_key("t1");
        chk("t1 core_key", core_key, KEY);
        chk("t1 core_mode", core_mode, 1);
        chk("t1 err", err_timeout, 0);
        send_block("t1 blk1", CT, 1'b0, EXP_IV);
        send_block("t2 blk2", CT, 1'b1, EXP_CHAIN);
        send_block("t2 blk3", CT, 1'b0, EXP_IV);

        // Backpressure on the output for 20 cycles.
        in_data = CT;
        in_last = 1'b1;
        in_valid = 1'b1;
        tick();
        in_data = ~CT;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("t4 out_valid", out_valid, 1);
        bad_vld = 0;
        bad_data = 0;
        bad_rdy = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1) bad_vld++;
            if (out_data !== EXP_CHAIN) bad_data++;
            if (in_ready !== 1'b0) bad_rdy++;
        end
        chk("t4 hold_valid", bad_vld, 0);
        chk("t4 hold_data", bad_data, 0);
        chk("t4 in_ready_low", bad_rdy, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4 drained", out_valid, 0);

        // Watchdog: the core never answers.
        done_en = 1'b0;
        in_data = CT;
        in_last = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3 core_ld", core_ld, 1);
        n = 0;
        bad_vld = 0;
        while (!err_timeout && n < 200) begin
            tick();
            n++;
            if (out_valid) bad_vld++;
        end
        chk("t3 timeout_cycles", n, 65);
        chk("t3 err", err_timeout, 1);
        chk("t3 no_out_valid", bad_vld, 0);
        chk("t3 in_ready", in_ready, 1);
        done_en = 1'b1;
        send_block("t3 after", CT, 1'b0, EXP_IV);
        chk("t3 err_sticky", err_timeout, 1);
        load_key("t3 reload");
        chk("t3 err_cleared", err_timeout, 0);

        // Key pulse during WAIT is ignored.
        core_lat = 6;
        in_data = CT;
        in_last = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        cfg_key_valid = 1'b1;
        tick();
        cfg_key_valid = 1'b0;
        chk("t5 kld_ignored", core_kld, 0);
        chk("t5 busy", busy, 1);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("t5 out_data", out_data, EXP_IV);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Key pulse and block in the same READY cycle: key wins.
        core_lat = 2;
        in_valid = 1'b1;
        cfg_key_valid = 1'b1;
        #1;
        chk("t5 in_ready_blocked", in_ready, 0);
        tick();
        cfg_key_valid = 1'b0;
        chk("t5 kld_taken", core_kld, 1);
        chk("t5 key_loaded_low", key_loaded, 0);
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("t5 accept_after_kwait", n, 11);
        send_block("t5 blk", CT, 1'b0, EXP_IV);

        // Reset in the middle of WAIT.
        core_lat = 30;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t6 busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6 busy", busy, 0);
        chk("t6 key_loaded", key_loaded, 0);
        chk("t6 in_ready", in_ready, 0);
        chk("t6 out_data", out_data, 0);
        chk("t6 core_text_in", core_text_in, 0);
        chk("t6 core_key", core_key, 0);
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("t6 idle_in_ready", in_ready, 0);
        chk("t6 idle_out_valid", out_valid, 0);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
